// File: rtl/casr_pkg.sv
// Shared definitions for the 11-bit hybrid rule 90/150 CASR: width, zero-state fix,
// checker states and the next-state function also used by the generator model.
package casr_pkg;

  localparam int CASR_W = 11;
  localparam logic [CASR_W-1:0] CASR_ZERO_FIX = 11'h001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } casr_state_e;

  // Rule 90 everywhere with null boundaries; the top cell adds itself (rule 150).
  function automatic logic [CASR_W-1:0] casr_next(input logic [CASR_W-1:0] s);
    logic [CASR_W-1:0] n;
    n = '0;
    if (s == '0) begin
      n = CASR_ZERO_FIX;
    end else begin
      n[0] = s[1];
      for (int k = 1; k < CASR_W - 1; k++) begin
        n[k] = s[k+1] ^ s[k-1];
      end
      n[CASR_W-1] = s[CASR_W-2] ^ s[CASR_W-1];
    end
    return n;
  endfunction

endpackage

// File: rtl/casr_core.sv
// Local CASR copy for the checker: load a seed, advance one step, or hold.
module casr_core
  import casr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CASR_W-1:0] seed,
  input  logic              load,
  input  logic              advance,
  output logic [CASR_W-1:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= casr_next(state);
    end
  end

endmodule

// File: rtl/casr_checker.sv
// Receive-side CASR pattern checker: bit-slip hunts for alignment, then counts bit errors
// over fixed windows and drops lock when too many errors land in one window.
module casr_checker
  import casr_pkg::*;
#(
  parameter int WIN_LEN     = 32,
  parameter int LOSS_THRESH = 8,
  parameter int TAP         = 0,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CASR_W-1:0] i_seed,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic              i_data,
  output logic              o_locked,
  output logic              o_err,
  output logic [CNT_W-1:0]  o_bit_cnt,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [15:0]       o_slip_cnt
);

  localparam int RUN_W = $clog2(WIN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(WIN_LEN - 1);
  localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_THRESH - 1);
  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  casr_state_e       fsm, fsm_next;
  logic [RUN_W-1:0]  run_cnt, run_next;
  logic [RUN_W-1:0]  win_bits, win_bits_next;
  logic [RUN_W-1:0]  win_err, win_err_next;
  logic              err_next;
  logic [CASR_W-1:0] casr_state;
  logic              mismatch;
  logic              advance;
  logic              bit_seen;

  assign mismatch = i_data ^ casr_state[TAP];
  assign bit_seen = i_valid && !i_load;
  // A HUNT mismatch holds the local CASR for one bit: that is the slip.
  assign advance  = bit_seen && ((fsm == LOCKED) || (fsm == HUNT && !mismatch));

  casr_core u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .seed    (i_seed),
    .load    (i_load),
    .advance (advance),
    .state   (casr_state)
  );

  always_comb begin
    fsm_next      = fsm;
    run_next      = run_cnt;
    win_bits_next = win_bits;
    win_err_next  = win_err;
    err_next      = 1'b0;
    if (i_load) begin
      fsm_next = HUNT;
      run_next = '0;
    end else if (i_valid) begin
      case (fsm)
        HUNT: begin
          if (mismatch) begin
            run_next = '0;
          end else if (run_cnt == RUN_LAST) begin
            fsm_next      = LOCKED;
            run_next      = '0;
            win_bits_next = '0;
            win_err_next  = '0;
          end else begin
            run_next = run_cnt + RUN_ONE;
          end
        end
        LOCKED: begin
          err_next = mismatch;
          // Loss of lock outranks the window wrap on the same bit.
          if (mismatch && win_err == LOSS_LAST) begin
            fsm_next = HUNT;
            run_next = '0;
          end else if (win_bits == RUN_LAST) begin
            win_bits_next = '0;
            win_err_next  = '0;
          end else begin
            win_bits_next = win_bits + RUN_ONE;
            win_err_next  = win_err + {{(RUN_W-1){1'b0}}, mismatch};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= IDLE;
      run_cnt  <= '0;
      win_bits <= '0;
      win_err  <= '0;
      o_locked <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      fsm      <= fsm_next;
      run_cnt  <= run_next;
      win_bits <= win_bits_next;
      win_err  <= win_err_next;
      o_locked <= (fsm_next == LOCKED);
      o_err    <= err_next;
    end
  end

  // Statistics saturate at all-ones; clear wins over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_bit_cnt  <= '0;
      o_err_cnt  <= '0;
      o_slip_cnt <= '0;
    end else if (i_clear) begin
      o_bit_cnt  <= '0;
      o_err_cnt  <= '0;
      o_slip_cnt <= '0;
    end else if (bit_seen) begin
      if (fsm == LOCKED) begin
        if (o_bit_cnt != '1) o_bit_cnt <= o_bit_cnt + CNT_ONE;
        if (mismatch && o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_ONE;
      end else if (fsm == HUNT && mismatch && o_slip_cnt != '1) begin
        o_slip_cnt <= o_slip_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_casr_checker.sv
// Randomized bench for casr_checker against a sequence-index reference model.
module tb_casr_checker;

  localparam int WIN_LEN     = 32;
  localparam int LOSS_THRESH = 8;
  localparam int TAP         = 0;
  localparam int CNT_W       = 32;
  localparam int M_IDLE = 0, M_HUNT = 1, M_LOCK = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [10:0]      i_seed;
  logic             i_load, i_clear, i_valid, i_data;
  logic             o_locked, o_err;
  logic [CNT_W-1:0] o_bit_cnt, o_err_cnt;
  logic [15:0]      o_slip_cnt;

  casr_checker #(
    .WIN_LEN(WIN_LEN), .LOSS_THRESH(LOSS_THRESH), .TAP(TAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_seed(i_seed), .i_load(i_load), .i_clear(i_clear),
    .i_valid(i_valid), .i_data(i_data), .o_locked(o_locked), .o_err(o_err),
    .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt), .o_slip_cnt(o_slip_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pattern orbit from 11'h001, built from the cell rule; positions are indices into it.
  logic [10:0] seq [0:4095];
  int period;
  int g_pos;

  int          m_mode, m_pos, m_run, m_wbits, m_werr;
  bit          m_zero, m_err;
  logic [31:0] m_bit, m_errc;
  logic [15:0] m_slip;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [10:0] rule_step(input logic [10:0] s);
    logic [10:0] n;
    for (int k = 0; k < 11; k++) begin
      n[k] = ((k < 10) ? s[k+1] : 1'b0) ^ ((k > 0) ? s[k-1] : 1'b0) ^ ((k == 10) ? s[k] : 1'b0);
    end
    return n;
  endfunction

  function automatic int index_of(input logic [10:0] s);
    for (int i = 0; i < period; i++) if (seq[i] == s) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_zero = 1; m_run = 0; m_wbits = 0; m_werr = 0;
    m_err = 0; m_bit = 0; m_errc = 0; m_slip = 0;
  endtask

  task automatic model_advance();
    if (m_zero) begin m_zero = 0; m_pos = 0; end
    else m_pos = (m_pos + 1) % period;
  endtask

  task automatic model_step(input bit load, input logic [10:0] seed, input bit clear,
                            input bit valid, input bit data);
    bit exp_bit, match, inc_bit, inc_err, inc_slip;
    inc_bit = 0; inc_err = 0; inc_slip = 0;
    exp_bit = m_zero ? 1'b0 : seq[m_pos][TAP];
    match = (data == exp_bit);
    m_err = 0;
    if (load) begin
      m_mode = M_HUNT; m_run = 0;
      if (seed == 11'd0) m_zero = 1;
      else begin m_zero = 0; m_pos = index_of(seed); end
    end else if (valid && m_mode == M_HUNT) begin
      if (match) begin
        model_advance(); m_run++;
        if (m_run == WIN_LEN) begin m_mode = M_LOCK; m_run = 0; m_wbits = 0; m_werr = 0; end
      end else begin
        m_run = 0; inc_slip = 1;
      end
    end else if (valid && m_mode == M_LOCK) begin
      model_advance(); inc_bit = 1; m_wbits++;
      if (!match) begin inc_err = 1; m_err = 1; m_werr++; end
      if (m_werr == LOSS_THRESH) begin m_mode = M_HUNT; m_run = 0; end
      else if (m_wbits == WIN_LEN) begin m_wbits = 0; m_werr = 0; end
    end
    if (clear) begin
      m_bit = 0; m_errc = 0; m_slip = 0;
    end else begin
      if (inc_bit && m_bit != 32'hFFFF_FFFF) m_bit++;
      if (inc_err && m_errc != 32'hFFFF_FFFF) m_errc++;
      if (inc_slip && m_slip != 16'hFFFF) m_slip++;
    end
  endtask

  task automatic compare_all(input string w);
    checkOutput({w, " locked"}, o_locked, (m_mode == M_LOCK));
    checkOutput({w, " err"}, o_err, m_err);
    checkOutput({w, " bit_cnt"}, o_bit_cnt, m_bit);
    checkOutput({w, " err_cnt"}, o_err_cnt, m_errc);
    checkOutput({w, " slip_cnt"}, o_slip_cnt, m_slip);
  endtask

  task automatic applyStimulus(input bit load, input logic [10:0] seed, input bit clear,
                               input bit valid, input bit data, input string w);
    i_load = load; i_seed = seed; i_clear = clear; i_valid = valid; i_data = data;
    model_step(load, seed, clear, valid, data);
    @(posedge clk); #1;
    i_load = 0; i_clear = 0; i_valid = 0;
    compare_all(w);
  endtask

  task automatic feed_gen(input bit flip, input bit clear, input string w);
    bit d;
    d = seq[g_pos][TAP] ^ flip;
    g_pos = (g_pos + 1) % period;
    applyStimulus(0, 11'd0, clear, 1, d, w);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; i_load = 0; i_clear = 0; i_valid = 0; i_data = 0; i_seed = 0;
    #2;
    model_reset();
    checkOutput("rst locked", o_locked, 0);
    checkOutput("rst err", o_err, 0);
    checkOutput("rst bit_cnt", o_bit_cnt, 0);
    checkOutput("rst err_cnt", o_err_cnt, 0);
    checkOutput("rst slip_cnt", o_slip_cnt, 0);
    #1 rst_n = 1;
    @(posedge clk); #1;
    compare_all("post_rst");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit k_flip;
    rst_n = 0; i_load = 0; i_clear = 0; i_valid = 0; i_data = 0; i_seed = 0;
    seq[0] = 11'h001;
    period = 1;
    while (period < 4096 && rule_step(seq[period-1]) != 11'h001) begin
      seq[period] = rule_step(seq[period-1]);
      period++;
    end
    model_reset();
    #3 rst_n = 1;
    do_reset();

    // Aligned stream from seed 1: lock on bit 32, then 168 locked bits.
    applyStimulus(1, 11'h001, 0, 0, 0, "s1_load");
    g_pos = 0;
    for (int i = 1; i <= 200; i++) begin
      feed_gen(0, 0, "s1");
      if (i == 31) checkOutput("s1 not_locked_31", o_locked, 0);
      if (i == 32) checkOutput("s1 locked_32", o_locked, 1);
    end
    checkOutput("s1 bit_cnt_168", o_bit_cnt, 168);
    checkOutput("s1 err_cnt_0", o_err_cnt, 0);
    checkOutput("s1 slip_cnt_0", o_slip_cnt, 0);

    // Generator 5 positions ahead: hunt by slipping until realigned.
    applyStimulus(1, seq[0], 1, 0, 0, "s2_load");
    g_pos = 5;
    n = 0;
    while (!o_locked && n < 10000) begin
      feed_gen(0, 0, "s2_hunt");
      n++;
    end
    checkOutput("s2 locked", o_locked, 1);
    checkOutput("s2 slipped", (o_slip_cnt != 16'd0), 1);
    for (int i = 0; i < 100; i++) feed_gen(0, 0, "s2_run");
    checkOutput("s2 err_cnt_0", o_err_cnt, 0);

    // Single flipped bit while locked.
    feed_gen(1, 0, "s3_flip");
    checkOutput("s3 err_pulse", o_err, 1);
    checkOutput("s3 err_cnt_1", o_err_cnt, 1);
    checkOutput("s3 still_locked", o_locked, 1);
    feed_gen(0, 0, "s3_after");
    checkOutput("s3 err_low", o_err, 0);

    // Eight errors inside one window drop lock; clean stream relocks.
    applyStimulus(0, 11'd0, 1, 0, 0, "s4_clear");
    n = 0;
    while (m_wbits != 0 && n < 64) begin feed_gen(0, 0, "s4_align"); n++; end
    for (int i = 1; i <= 8; i++) begin
      feed_gen(1, 0, "s4_flip");
      if (i == 7) checkOutput("s4 locked_at_7", o_locked, 1);
    end
    checkOutput("s4 lost_at_8", o_locked, 0);
    n = 0;
    while (!o_locked && n < 40) begin feed_gen(0, 0, "s4_relock"); n++; end
    checkOutput("s4 relocked", o_locked, 1);
    checkOutput("s4 relock_bits", n, 32);

    // Valid gaps must not change the counts of the aligned run.
    do_reset();
    applyStimulus(1, 11'h001, 0, 0, 0, "s5_load");
    g_pos = 0;
    n = 0;
    while (n < 200) begin
      if ($urandom_range(1) == 1) begin feed_gen(0, 0, "s5"); n++; end
      else applyStimulus(0, 11'd0, 0, 0, 1'($urandom_range(1)), "s5_gap");
    end
    checkOutput("s5 bit_cnt_168", o_bit_cnt, 168);
    checkOutput("s5 err_cnt_0", o_err_cnt, 0);
    checkOutput("s5 slip_cnt_0", o_slip_cnt, 0);
    checkOutput("s5 locked", o_locked, 1);

    // Clear beats a coincident error; load drops the coincident bit.
    feed_gen(1, 1, "s6_clear_err");
    checkOutput("s6 err_cnt_cleared", o_err_cnt, 0);
    checkOutput("s6 err_pulse", o_err, 1);
    applyStimulus(1, seq[g_pos], 0, 1, ~seq[g_pos][TAP], "s6_load_valid");
    checkOutput("s6 hunt_after_load", o_locked, 0);
    checkOutput("s6 no_slip_on_drop", o_slip_cnt, 0);
    for (int i = 0; i < 33; i++) feed_gen(0, 0, "s6_relock");
    checkOutput("s6 locked_again", o_locked, 1);
    do_reset();

    // Seed 0: first matching bit is 0, then the CASR continues from 11'h001.
    applyStimulus(1, 11'd0, 0, 0, 0, "s8_load0");
    applyStimulus(0, 11'd0, 0, 1, 0, "s8_zero_bit");
    g_pos = 0;
    for (int i = 0; i < 32; i++) feed_gen(0, 0, "s8");
    checkOutput("s8 locked", o_locked, 1);
    checkOutput("s8 slip_cnt_0", o_slip_cnt, 0);

    // Random mix of loads, clears, gaps and flips.
    for (int i = 0; i < 3000; i++) begin
      int r, kk;
      r = $urandom_range(99);
      if (r < 2) begin
        kk = $urandom_range(period - 1);
        g_pos = (kk + $urandom_range(3)) % period;
        applyStimulus(1, seq[kk], 1'($urandom_range(1)), 1'($urandom_range(1)),
                      1'($urandom_range(1)), "s7_load");
      end else if (r < 30) begin
        applyStimulus(0, 11'd0, (r < 4), 0, 1'($urandom_range(1)), "s7_gap");
      end else begin
        k_flip = ($urandom_range(99) < 3);
        feed_gen(k_flip, ($urandom_range(99) < 2), "s7");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
